p2s_serializer: RTL

P2S_SERIALIZER -- requirements
Module: p2s_serializer

---
 rtl/msdap_pkg.sv | 20 ++
 rtl/p2s_bit_counter.sv | 26 ++
 rtl/p2s_serializer.sv | 115 +++++++++++
 3 files changed

// File: rtl/msdap_pkg.sv
// Shared types and constants for the parallel-to-serial transmit path.
package msdap_pkg;

  localparam int WORD_W    = 40;
  localparam int CNT_MIN_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2
  } p2s_state_e;

  // Counter width able to reach 'last', never narrower than CNT_MIN_W.
  function automatic int cnt_width(input int last);
    int w;
    w = $clog2(last + 1);
    return (w < CNT_MIN_W) ? CNT_MIN_W : w;
  endfunction

endpackage

// File: rtl/p2s_bit_counter.sv
// Bit-slot counter: counts 0..LAST while enabled, wraps to 0 after LAST,
// and flags the terminal slot on o_done.
module p2s_bit_counter #(
  parameter int CNT_W = 6,
  parameter int LAST  = 39
) (
  input  logic clk,
  input  logic srst,
  input  logic i_restart,
  input  logic i_enable,
  output logic o_done
);

  logic [CNT_W-1:0] r_count;

  assign o_done = (r_count == CNT_W'(LAST));

  always_ff @(posedge clk) begin
    if (srst || i_restart) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= o_done ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/p2s_serializer.sv
// Double-buffered MSB-first serializer with frame-synchronised word start.
// Defining P2S_PARITY_EN appends one even-parity slot after each word's LSB.
module p2s_serializer
  import msdap_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             start,
  input  logic             p2s_load,
  input  logic             p2s_clear,
  input  logic [WIDTH-1:0] data_in,
  input  logic             frame,
  output logic             serial_out,
  output logic             out_ready,
  output logic             hold_full,
  output logic             overrun
);

`ifdef P2S_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif
  localparam int CNT_W = cnt_width(LAST);

  p2s_state_e       r_state;
  p2s_state_e       w_state_next;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] r_shift;
  logic             r_hold_full;
  logic             r_overrun;
  logic             w_transfer;
  logic             w_done;

  // Clear suppresses a frame that would otherwise launch a word this cycle.
  assign w_transfer = (r_state == ARMED) && frame && !p2s_clear;
  assign hold_full  = r_hold_full;
  assign overrun    = r_overrun;

  p2s_bit_counter #(
    .CNT_W (CNT_W),
    .LAST  (LAST)
  ) u_bit_counter (
    .clk       (clk),
    .srst      (start),
    .i_restart (p2s_clear),
    .i_enable  (r_state == SHIFT),
    .o_done    (w_done)
  );

`ifdef P2S_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk) begin
    if (start || p2s_clear) begin
      r_parity <= 1'b0;
    end else if (w_transfer) begin
      r_parity <= ^r_hold;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (start) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    out_ready    = 1'b0;
    serial_out   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_hold_full) w_state_next = ARMED;
      end
      ARMED: begin
        if (frame) w_state_next = SHIFT;
      end
      SHIFT: begin
        out_ready  = 1'b1;
        serial_out = r_shift[WIDTH-1];
`ifdef P2S_PARITY_EN
        if (w_done) serial_out = r_parity;
`endif
        if (w_done) w_state_next = r_hold_full ? ARMED : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (p2s_clear) w_state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (start || p2s_clear) begin
      r_hold      <= '0;
      r_shift     <= '0;
      r_hold_full <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_transfer) begin
        r_shift <= r_hold;
      end else if (r_state == SHIFT) begin
        r_shift <= {r_shift[WIDTH-2:0], 1'b0};
      end
      if (p2s_load) r_hold <= data_in;
      // A load in the transfer cycle refills the buffer just emptied, so no overrun.
      r_hold_full <= p2s_load || (r_hold_full && !w_transfer);
      if (p2s_load && r_hold_full && !w_transfer) r_overrun <= 1'b1;
    end
  end

endmodule
